// File: rtl/warp_fetcher.sv
// rtl/warp_fetcher.sv - two-warp instruction fetch stage with one cached entry per warp
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   core_state               scheduler state of the selected warp (FETCH=1 starts fetches)
//   warp_select, current_pc  selected warp and its PC
//   flush                    invalidate both cached entries
//   fetcher_state            FET_IDLE=0 / FET_FETCHING=1 / FET_DONE=2
//   instruction              cached instruction of the selected warp (0 when invalid)
//   mem_read_valid/address   single outstanding program-memory read request
//   mem_read_ready/data      request accepted; data valid in the same cycle

module warp_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic                             warp_select,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data
);

    localparam logic [2:0] CORE_FETCH   = 3'd1;
    localparam logic [2:0] FET_IDLE     = 3'd0;
    localparam logic [2:0] FET_FETCHING = 3'd1;
    localparam logic [2:0] FET_DONE     = 3'd2;

    typedef enum logic {M_IDLE = 1'b0, M_REQ = 1'b1} req_state_t;

    req_state_t state_q, state_d;

    logic [1:0]                       entry_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] entry_tag_q  [2];
    logic [PROGRAM_MEM_DATA_BITS-1:0] entry_data_q [2];

    logic                             req_warp_q, req_warp_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_pc_q, req_pc_d;

    logic in_fetch;
    logic hit;
    logic launch;
    logic accept;

    assign in_fetch = (core_state == CORE_FETCH);
    assign hit      = entry_valid_q[warp_select] && (entry_tag_q[warp_select] == current_pc);
    // A miss of the other warp waits here until the FSM is back in M_IDLE.
    assign launch   = (state_q == M_IDLE) && in_fetch && !hit && !flush;
    assign accept   = (state_q == M_REQ) && mem_read_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= M_IDLE;
            req_warp_q <= 1'b0;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_warp_q <= req_warp_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        req_warp_d = req_warp_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            M_IDLE: begin
                if (launch) begin
                    state_d    = M_REQ;
                    req_warp_d = warp_select;
                    req_pc_d   = current_pc;
                end
            end
            M_REQ: begin
                // No reissue in the accept cycle: launch only evaluates in M_IDLE.
                if (mem_read_ready) begin
                    state_d = M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    // Output logic; request outputs are derived from registered state so they
    // stay stable for the whole M_REQ period.
    always_comb begin
        mem_read_valid   = (state_q == M_REQ);
        mem_read_address = (state_q == M_REQ) ? req_pc_q : '0;
        instruction      = entry_valid_q[warp_select] ? entry_data_q[warp_select] : '0;
        if (in_fetch && hit) begin
            fetcher_state = FET_DONE;
        end else if (state_q == M_REQ) begin
            fetcher_state = FET_FETCHING;
        end else if (in_fetch) begin
            fetcher_state = FET_FETCHING;
        end else begin
            fetcher_state = FET_IDLE;
        end
    end

    // Cache entries. The response always lands in the issuing warp's entry;
    // a flush in the same cycle leaves that entry invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid_q <= 2'b00;
        end else begin
            if (flush) begin
                entry_valid_q <= 2'b00;
            end else if (accept) begin
                entry_valid_q[req_warp_q] <= 1'b1;
            end
        end
        if (!reset && accept) begin
            entry_tag_q[req_warp_q]  <= req_pc_q;
            entry_data_q[req_warp_q] <= mem_read_data;
        end
    end

endmodule

// File: tb/tb_warp_fetcher.sv
// tb/tb_warp_fetcher.sv - directed self-checking bench for warp_fetcher

module tb_warp_fetcher;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic        warp_select;
    logic [7:0]  current_pc;
    logic        flush;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_FETCH  = 3'd1;
    localparam logic [2:0] C_DECODE = 3'd2;

    warp_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .warp_select      (warp_select),
        .current_pc       (current_pc),
        .flush            (flush),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] cs, input logic w, input logic [7:0] pc);
        core_state  = cs;
        warp_select = w;
        current_pc  = pc;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        core_state     = C_IDLE;
        warp_select    = 1'b0;
        current_pc     = 8'h00;
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        step();
        step();
        chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("rst_addr",  {24'd0, mem_read_address}, 32'd0);
        chk("rst_fstate", {29'd0, fetcher_state}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'd0);

        // Start a request, then reset for two cycles mid-request
        reset = 1'b0;
        set_in(C_FETCH, 1'b0, 8'h00);
        chk("pre_launch_fstate", {29'd0, fetcher_state}, 32'd1);
        step();
        chk("pre_req_valid", {31'd0, mem_read_valid}, 32'd1);
        reset = 1'b1;
        set_in(C_IDLE, 1'b0, 8'h00);
        step();
        step();
        chk("midreq_rst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("midreq_rst_fstate", {29'd0, fetcher_state}, 32'd0);
        chk("midreq_rst_instr", {16'd0, instruction}, 32'd0);
        reset = 1'b0;

        // Cold miss at pc 0 for warp 0
        set_in(C_FETCH, 1'b0, 8'h00);
        chk("cold_fstate", {29'd0, fetcher_state}, 32'd1);
        chk("cold_novalid_yet", {31'd0, mem_read_valid}, 32'd0);
        step();
        chk("cold_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("cold_addr", {24'd0, mem_read_address}, 32'h00);
        step();
        step();
        chk("cold_hold_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("cold_hold_addr", {24'd0, mem_read_address}, 32'h00);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5101;
        #1;
        chk("cold_accept_fstate", {29'd0, fetcher_state}, 32'd1);
        step();
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        #1;
        chk("cold_done_fstate", {29'd0, fetcher_state}, 32'd2);
        chk("cold_done_instr", {16'd0, instruction}, 32'h5101);
        chk("cold_done_valid", {31'd0, mem_read_valid}, 32'd0);

        // Hit: leave FETCH, then re-enter at pc 0
        set_in(C_DECODE, 1'b0, 8'h00);
        chk("decode_instr", {16'd0, instruction}, 32'h5101);
        chk("decode_fstate", {29'd0, fetcher_state}, 32'd0);
        step();
        set_in(C_FETCH, 1'b0, 8'h00);
        chk("hit_fstate", {29'd0, fetcher_state}, 32'd2);
        step();
        chk("hit_no_req", {31'd0, mem_read_valid}, 32'd0);

        // Warp switch during an outstanding miss
        set_in(C_FETCH, 1'b0, 8'h05);
        chk("sw_w0_fstate", {29'd0, fetcher_state}, 32'd1);
        step();
        chk("sw_w0_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("sw_w0_addr", {24'd0, mem_read_address}, 32'h05);
        set_in(C_FETCH, 1'b1, 8'h09);
        chk("sw_w1_fstate", {29'd0, fetcher_state}, 32'd1);
        chk("sw_w1_instr", {16'd0, instruction}, 32'h0000);
        step();
        chk("sw_no_second_req", {24'd0, mem_read_address}, 32'h05);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hA00F;
        step();
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        #1;
        chk("sw_no_same_cycle_reissue", {31'd0, mem_read_valid}, 32'd0);
        chk("sw_w1_wait_fstate", {29'd0, fetcher_state}, 32'd1);
        step();
        chk("sw_w1_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("sw_w1_addr", {24'd0, mem_read_address}, 32'h09);
        set_in(C_FETCH, 1'b0, 8'h05);
        chk("sw_w0_hit_fstate", {29'd0, fetcher_state}, 32'd2);
        chk("sw_w0_hit_instr", {16'd0, instruction}, 32'hA00F);
        set_in(C_FETCH, 1'b1, 8'h09);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        step();
        mem_read_ready = 1'b0;
        #1;
        chk("sw_w1_done_fstate", {29'd0, fetcher_state}, 32'd2);
        chk("sw_w1_done_instr", {16'd0, instruction}, 32'h1234);

        // Replacement of warp 1 entry
        set_in(C_FETCH, 1'b1, 8'h0A);
        chk("rep_miss_fstate", {29'd0, fetcher_state}, 32'd1);
        step();
        chk("rep_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("rep_addr", {24'd0, mem_read_address}, 32'h0A);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h2222;
        step();
        mem_read_ready = 1'b0;
        #1;
        chk("rep_new_hit", {29'd0, fetcher_state}, 32'd2);
        chk("rep_new_instr", {16'd0, instruction}, 32'h2222);
        set_in(C_FETCH, 1'b1, 8'h09);
        chk("rep_old_miss", {29'd0, fetcher_state}, 32'd1);
        set_in(C_FETCH, 1'b0, 8'h05);
        chk("rep_w0_hit", {29'd0, fetcher_state}, 32'd2);
        chk("rep_w0_instr", {16'd0, instruction}, 32'hA00F);

        // Flush with both entries valid
        set_in(C_IDLE, 1'b0, 8'h05);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(C_FETCH, 1'b0, 8'h05);
        chk("fl_w0_miss", {29'd0, fetcher_state}, 32'd1);
        chk("fl_w0_instr", {16'd0, instruction}, 32'h0000);
        step();
        chk("fl_w0_addr", {24'd0, mem_read_address}, 32'h05);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3333;
        step();
        mem_read_ready = 1'b0;
        set_in(C_FETCH, 1'b1, 8'h0A);
        chk("fl_w1_miss", {29'd0, fetcher_state}, 32'd1);
        step();
        chk("fl_w1_valid", {31'd0, mem_read_valid}, 32'd1);
        chk("fl_w1_addr", {24'd0, mem_read_address}, 32'h0A);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h4444;
        step();
        mem_read_ready = 1'b0;
        #1;
        chk("fl_w1_done", {29'd0, fetcher_state}, 32'd2);
        chk("fl_w1_instr", {16'd0, instruction}, 32'h4444);

        // Response accepted in the same cycle as flush stays invalid
        set_in(C_FETCH, 1'b0, 8'h14);
        step();
        chk("flr_addr", {24'd0, mem_read_address}, 32'h14);
        set_in(C_IDLE, 1'b0, 8'h14);
        flush          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5555;
        step();
        flush          = 1'b0;
        mem_read_ready = 1'b0;
        set_in(C_FETCH, 1'b0, 8'h14);
        chk("flr_w0_miss", {29'd0, fetcher_state}, 32'd1);
        chk("flr_w0_instr", {16'd0, instruction}, 32'h0000);
        set_in(C_FETCH, 1'b1, 8'h0A);
        chk("flr_w1_miss", {29'd0, fetcher_state}, 32'd1);
        set_in(C_IDLE, 1'b0, 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
